// File: rtl/pixel_scan_timer.sv
// Pixel scan timer: recovers one pixel tick per edge of the divider's toggle flag and runs
// the horizontal/vertical scan timing (syncs, active video, coordinates, line/frame strobes).
module pixel_scan_timer #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CNT_W    = 10
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic             pixel_toggle,
    output logic             hsync,
    output logic             vsync,
    output logic             active_video,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    typedef enum logic [2:0] {StIdle, StHAct, StHFp, StHSync, StHBp} h_state_e;
    typedef enum logic [1:0] {StVAct, StVFp, StVSync, StVBp} v_state_e;

    h_state_e         h_state_q, h_state_d;
    v_state_e         v_state_q, v_state_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] h_last, v_last;
    logic             toggle_q;
    logic             tick;
    logic             act_d, line_start_d, frame_start_d;

    assign tick = enable & (pixel_toggle != toggle_q);

    // Last counter value of the current region; the region ends on the tick at this value.
    always_comb begin
        h_last = '0;
        unique case (h_state_q)
            StHAct:  h_last = CNT_W'(H_ACTIVE - 1);
            StHFp:   h_last = CNT_W'(H_FP - 1);
            StHSync: h_last = CNT_W'(H_SYNC - 1);
            StHBp:   h_last = CNT_W'(H_BP - 1);
            default: h_last = '0;
        endcase
    end

    always_comb begin
        v_last = '0;
        unique case (v_state_q)
            StVAct:  v_last = CNT_W'(V_ACTIVE - 1);
            StVFp:   v_last = CNT_W'(V_FP - 1);
            StVSync: v_last = CNT_W'(V_SYNC - 1);
            StVBp:   v_last = CNT_W'(V_BP - 1);
            default: v_last = '0;
        endcase
    end

    // Position after the next tick; only committed when tick is high.
    always_comb begin
        h_state_d = h_state_q;
        h_cnt_d   = h_cnt_q;
        v_state_d = v_state_q;
        v_cnt_d   = v_cnt_q;
        if (h_state_q == StIdle) begin
            h_state_d = StHAct;
            h_cnt_d   = '0;
            v_state_d = StVAct;
            v_cnt_d   = '0;
        end else if (h_cnt_q != h_last) begin
            h_cnt_d = h_cnt_q + 1'b1;
        end else begin
            h_cnt_d = '0;
            unique case (h_state_q)
                StHAct:  h_state_d = StHFp;
                StHFp:   h_state_d = StHSync;
                StHSync: h_state_d = StHBp;
                StHBp:   h_state_d = StHAct;
                default: h_state_d = StIdle;
            endcase
            // The vertical machine steps on the H_BP -> H_ACT tick, aligning vsync to line start.
            if (h_state_q == StHBp) begin
                if (v_cnt_q != v_last) begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end else begin
                    v_cnt_d = '0;
                    unique case (v_state_q)
                        StVAct:  v_state_d = StVFp;
                        StVFp:   v_state_d = StVSync;
                        StVSync: v_state_d = StVBp;
                        StVBp:   v_state_d = StVAct;
                        default: v_state_d = StVAct;
                    endcase
                end
            end
        end
    end

    assign act_d         = (h_state_d == StHAct) && (v_state_d == StVAct);
    assign line_start_d  = act_d && (h_cnt_d == '0);
    assign frame_start_d = line_start_d && (v_cnt_d == '0);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            toggle_q     <= 1'b0;
            h_state_q    <= StIdle;
            v_state_q    <= StVAct;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            active_video <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            // Tracks even while disabled so re-enabling never sees a stale edge.
            toggle_q    <= pixel_toggle;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (tick) begin
                h_state_q    <= h_state_d;
                v_state_q    <= v_state_d;
                h_cnt_q      <= h_cnt_d;
                v_cnt_q      <= v_cnt_d;
                hsync        <= (h_state_d != StHSync);
                vsync        <= (v_state_d != StVSync);
                active_video <= act_d;
                x            <= act_d ? h_cnt_d : '0;
                y            <= act_d ? v_cnt_d : '0;
                line_start   <= line_start_d;
                frame_start  <= frame_start_d;
            end
        end
    end

endmodule

// File: tb/tb_pixel_scan_timer.sv
// Bench for pixel_scan_timer: directed scenarios plus random toggles/enable/reset, every cycle
// checked against a linear frame-position model (tick index -> line/column arithmetic).
module tb_pixel_scan_timer;

    localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int unsigned CW = 10;
    localparam int unsigned LINE  = HA + HF + HS + HB;
    localparam int unsigned FRAME = LINE * (VA + VF + VS + VB);

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          enable = 1'b1;
    logic          pixel_toggle = 1'b0;
    logic          hsync, vsync, active_video, line_start, frame_start;
    logic [CW-1:0] x, y;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model: started flag plus the tick index within the frame.
    bit          m_tq = 1'b0;
    bit          m_started = 1'b0;
    bit          m_tick = 1'b0;
    int unsigned m_p = 0;

    always #5 clk = ~clk;

    pixel_scan_timer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CNT_W(CW)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .enable      (enable),
        .pixel_toggle(pixel_toggle),
        .hsync       (hsync),
        .vsync       (vsync),
        .active_video(active_video),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        int unsigned hp, ln;
        bit act;
        hp  = m_p % LINE;
        ln  = m_p / LINE;
        act = m_started && (hp < HA) && (ln < VA);
        check("hsync", 32'(hsync),
              32'(!(m_started && hp >= HA + HF && hp < HA + HF + HS)));
        check("vsync", 32'(vsync),
              32'(!(m_started && ln >= VA + VF && ln < VA + VF + VS)));
        check("active_video", 32'(active_video), 32'(act));
        check("x", 32'(x), act ? hp : 32'd0);
        check("y", 32'(y), act ? ln : 32'd0);
        check("line_start", 32'(line_start), 32'(m_tick && act && hp == 0));
        check("frame_start", 32'(frame_start), 32'(m_tick && m_p == 0));
    endtask

    // One clock: advance the model with the inputs sampled at the edge, then compare.
    task automatic step();
        bit tick;
        @(posedge clk);
        if (!n_rst) begin
            m_tq      = 1'b0;
            m_started = 1'b0;
            m_tick    = 1'b0;
        end else begin
            tick   = enable && (pixel_toggle != m_tq);
            m_tq   = pixel_toggle;
            m_tick = tick;
            if (tick) begin
                if (!m_started) begin
                    m_started = 1'b1;
                    m_p       = 0;
                end else begin
                    m_p = (m_p + 1) % FRAME;
                end
            end
        end
        #1;
        compare_all();
    endtask

    task automatic toggle_step();
        pixel_toggle = ~pixel_toggle;
        step();
    endtask

    initial begin
        int unsigned vs_low;
        vs_low = 0;

        // Reset, then regular toggling every 4 clk through a full frame and into the next.
        repeat (3) step();
        n_rst = 1'b1;
        repeat (2) step();
        for (int i = 1; i <= 50; i++) begin
            toggle_step();
            if (i == 1 || i == 49) check("frame_start_tick", 32'(frame_start), 32'd1);
            if (i <= 48 && !vsync) vs_low++;
            repeat (3) step();
        end
        check("vsync_low_ticks", vs_low, LINE * VS);

        // Hold with enable low while toggling, then resume.
        enable = 1'b0;
        repeat (3) begin
            toggle_step();
            step();
        end
        enable = 1'b1;
        repeat (3) step();
        toggle_step();
        repeat (2) step();

        // Back-to-back toggles, then a held toggle level.
        toggle_step();
        toggle_step();
        toggle_step();
        repeat (5) step();

        // Mid-frame reset for one clock, then restart.
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        repeat (2) step();
        toggle_step();
        repeat (3) step();

        // Random toggles, enable drops and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(99) < 45) pixel_toggle = ~pixel_toggle;
            if ($urandom_range(99) < 5) enable = ~enable;
            n_rst = ($urandom_range(999) < 4) ? 1'b0 : 1'b1;
            step();
        end
        n_rst  = 1'b1;
        enable = 1'b1;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
